// File: rtl/vector_writeback_arbiter.sv
// Vector register-file writeback arbiter.
// Two requesters (ALU and LSU) each feed a 2-entry buffer of
// {wsel, wen, wdata}. A round-robin arbiter selects one buffered entry
// per cycle and drives the registered register-file write port.
// Writes to r0 are suppressed but still consume a grant.
module vector_writeback_arbiter #(
  parameter int THREADS = 4,
  parameter int WORD_W  = 32
) (
  input  logic                      clk,
  input  logic                      nRST,
  // ALU writeback request
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [4:0]                alu_wsel,
  input  logic [THREADS-1:0]        alu_wen,
  input  logic [THREADS*WORD_W-1:0] alu_wdata,
  // LSU writeback request
  input  logic                      lsu_valid,
  output logic                      lsu_ready,
  input  logic [4:0]                lsu_wsel,
  input  logic [THREADS-1:0]        lsu_wen,
  input  logic [THREADS*WORD_W-1:0] lsu_wdata,
  // Register-file write port
  output logic [4:0]                rf_wsel,
  output logic [THREADS-1:0]        rf_wen,
  output logic [THREADS*WORD_W-1:0] rf_wdata,
  output logic                      idle
);

  localparam int ALU = 0;
  localparam int LSU = 1;

  typedef struct packed {
    logic [4:0]                wsel;
    logic [THREADS-1:0]        wen;
    logic [THREADS*WORD_W-1:0] wdata;
  } entry_t;

  // Which requester wins when both buffers hold an entry.
  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_LSU = 1'b1
  } pri_e;

  // Per-requester buffer state, indexed by ALU / LSU.
  entry_t     mem       [2][2];
  entry_t     in_entry  [2];
  entry_t     head      [2];
  logic [1:0] count     [2];
  logic       wr_ptr    [2];
  logic       rd_ptr    [2];
  logic       push      [2];
  logic       pop       [2];
  logic       ready     [2];
  logic       has_entry [2];
  logic       req_valid [2];

  pri_e   pri_q;
  pri_e   pri_d;
  logic   grant_valid;
  logic   grant_sel;
  entry_t grant_entry;

  assign in_entry[ALU]  = '{wsel: alu_wsel, wen: alu_wen, wdata: alu_wdata};
  assign in_entry[LSU]  = '{wsel: lsu_wsel, wen: lsu_wen, wdata: lsu_wdata};
  assign req_valid[ALU] = alu_valid;
  assign req_valid[LSU] = lsu_valid;

  // Ready depends on occupancy alone, so a full buffer refuses a push even
  // when the arbiter is about to pop it this same cycle.
  assign alu_ready = ready[ALU];
  assign lsu_ready = ready[LSU];

  // Per-buffer handshake and status decode.
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      ready[r]     = (count[r] != 2'd2);
      has_entry[r] = (count[r] != 2'd0);
      push[r]      = req_valid[r] && ready[r];
      head[r]      = mem[r][rd_ptr[r]];
    end
  end

  // Buffer payload storage, written on accepted requests only.
  // NOTE: payload is deliberately left out of reset; count alone says which
  // slots hold live data, so resetting the wide storage would buy nothing.
  always_ff @(posedge clk) begin
    for (int r = 0; r < 2; r++) begin
      if (push[r]) begin
        mem[r][wr_ptr[r]] <= in_entry[r];
      end
    end
  end

  // Buffer pointers and occupancy; push and pop at count 1 leave it at 1
  // with the new entry becoming the head.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int r = 0; r < 2; r++) begin
        count[r]  <= 2'd0;
        wr_ptr[r] <= 1'b0;
        rd_ptr[r] <= 1'b0;
      end
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (push[r]) begin
          wr_ptr[r] <= ~wr_ptr[r];
        end
        if (pop[r]) begin
          rd_ptr[r] <= ~rd_ptr[r];
        end
        case ({push[r], pop[r]})
          2'b10:   count[r] <= count[r] + 2'd1;
          2'b01:   count[r] <= count[r] - 2'd1;
          default: count[r] <= count[r];
        endcase
      end
    end
  end

  // Arbitration: a lone non-empty buffer always wins; on contention the
  // priority pointer decides, then points at the loser for next time.
  // NOTE: every output of this block gets a default first so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = 1'b0;
    pri_d       = pri_q;
    pop[ALU]    = 1'b0;
    pop[LSU]    = 1'b0;
    if (has_entry[ALU] && has_entry[LSU]) begin
      grant_valid = 1'b1;
      grant_sel   = (pri_q == PRI_LSU);
    end else if (has_entry[ALU]) begin
      grant_valid = 1'b1;
      grant_sel   = 1'b0;
    end else if (has_entry[LSU]) begin
      grant_valid = 1'b1;
      grant_sel   = 1'b1;
    end
    if (grant_valid) begin
      pop[grant_sel] = 1'b1;
      pri_d          = grant_sel ? PRI_ALU : PRI_LSU;
    end
  end

  assign grant_entry = head[grant_sel];

  // Priority pointer register.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      pri_q <= PRI_ALU;
    end else begin
      pri_q <= pri_d;
    end
  end

  // Registered write port: a grant loads the head; r0 is never enabled.
  // Without a grant only the enables drop, select and data hold.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      rf_wsel  <= 5'd0;
      rf_wen   <= '0;
      rf_wdata <= '0;
    end else if (grant_valid) begin
      rf_wsel  <= grant_entry.wsel;
      rf_wen   <= (grant_entry.wsel == 5'd0) ? '0 : grant_entry.wen;
      rf_wdata <= grant_entry.wdata;
    end else begin
      rf_wen   <= '0;
    end
  end

  assign idle = (count[ALU] == 2'd0) && (count[LSU] == 2'd0) && (rf_wen == '0);

  // Structural invariants: occupancy bounded, r0 never written, and the
  // arbiter never pops an empty buffer.
  a_alu_count_max: assert property (@(posedge clk) disable iff (!nRST)
    count[ALU] <= 2'd2);
  a_lsu_count_max: assert property (@(posedge clk) disable iff (!nRST)
    count[LSU] <= 2'd2);
  a_no_r0_write: assert property (@(posedge clk) disable iff (!nRST)
    (rf_wsel == 5'd0) |-> (rf_wen == '0));
  a_no_empty_pop: assert property (@(posedge clk) disable iff (!nRST)
    grant_valid |-> has_entry[grant_sel]);

endmodule

// File: tb/tb_vector_writeback_arbiter.sv
// Self-checking bench for vector_writeback_arbiter.
// A queue-level reference model predicts every register-file write and
// its cycle; a monitor compares the DUT write port against that
// scoreboard, and a register-file image is compared at the end.
module tb_vector_writeback_arbiter;

  localparam int THREADS = 4;
  localparam int WORD_W  = 32;
  localparam int DW      = THREADS * WORD_W;

  typedef struct {
    logic [4:0]         wsel;
    logic [THREADS-1:0] wen;
    logic [DW-1:0]      wdata;
  } req_t;

  typedef struct {
    logic [4:0]         wsel;
    logic [THREADS-1:0] wen;
    logic [DW-1:0]      wdata;
    int                 due;
  } wr_t;

  logic               clk = 1'b0;
  logic               nRST = 1'b0;
  logic               alu_valid = 1'b0;
  logic               alu_ready;
  logic [4:0]         alu_wsel = '0;
  logic [THREADS-1:0] alu_wen = '0;
  logic [DW-1:0]      alu_wdata = '0;
  logic               lsu_valid = 1'b0;
  logic               lsu_ready;
  logic [4:0]         lsu_wsel = '0;
  logic [THREADS-1:0] lsu_wen = '0;
  logic [DW-1:0]      lsu_wdata = '0;
  logic [4:0]         rf_wsel;
  logic [THREADS-1:0] rf_wen;
  logic [DW-1:0]      rf_wdata;
  logic               idle;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  req_t               alu_q[$];
  req_t               lsu_q[$];
  wr_t                exp_q[$];
  bit                 pri_lsu = 1'b0;
  logic [THREADS-1:0] exp_wen_now = '0;
  int                 cyc = 0;
  logic [DW-1:0]      exp_rf [32] = '{default: '0};
  logic [DW-1:0]      act_rf [32] = '{default: '0};

  vector_writeback_arbiter #(.THREADS(THREADS), .WORD_W(WORD_W)) dut (
    .clk       (clk),
    .nRST      (nRST),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_wsel  (alu_wsel),
    .alu_wen   (alu_wen),
    .alu_wdata (alu_wdata),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_wsel  (lsu_wsel),
    .lsu_wen   (lsu_wen),
    .lsu_wdata (lsu_wdata),
    .rf_wsel   (rf_wsel),
    .rf_wen    (rf_wen),
    .rf_wdata  (rf_wdata),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < THREADS; i++) d[i*WORD_W +: WORD_W] = $urandom;
    return d;
  endfunction

  function automatic req_t mk(input logic [4:0] wsel, input logic [THREADS-1:0] wen,
                              input logic [DW-1:0] wdata);
    req_t r;
    r.wsel  = wsel;
    r.wen   = wen;
    r.wdata = wdata;
    return r;
  endfunction

  // One clock edge of the reference model: arbitrate on what was buffered
  // before this edge, then accept new requests against pre-edge occupancy.
  task automatic model_step();
    int   na;
    int   nl;
    bit   acc_a;
    bit   acc_l;
    int   g;
    req_t e;
    na    = alu_q.size();
    nl    = lsu_q.size();
    acc_a = alu_valid && (na < 2);
    acc_l = lsu_valid && (nl < 2);
    cyc++;
    g = -1;
    if (na > 0 && nl > 0) g = pri_lsu ? 1 : 0;
    else if (na > 0)      g = 0;
    else if (nl > 0)      g = 1;
    exp_wen_now = '0;
    if (g >= 0) begin
      if (g == 0) e = alu_q.pop_front();
      else        e = lsu_q.pop_front();
      pri_lsu = (g == 0);
      if (e.wsel != 5'd0 && e.wen != '0) begin
        exp_wen_now = e.wen;
        for (int i = 0; i < THREADS; i++)
          if (e.wen[i]) exp_rf[e.wsel][i*WORD_W +: WORD_W] = e.wdata[i*WORD_W +: WORD_W];
        exp_q.push_back('{wsel: e.wsel, wen: e.wen, wdata: e.wdata, due: cyc});
      end
    end
    if (acc_a) alu_q.push_back(mk(alu_wsel, alu_wen, alu_wdata));
    if (acc_l) lsu_q.push_back(mk(lsu_wsel, lsu_wen, lsu_wdata));
  endtask

  // Reference model process; reset discards everything immediately.
  initial forever begin
    @(posedge clk or negedge nRST);
    if (!nRST) begin
      alu_q.delete();
      lsu_q.delete();
      exp_q.delete();
      pri_lsu     = 1'b0;
      exp_wen_now = '0;
    end else begin
      model_step();
    end
  end

  // Monitor: whenever the DUT presents a write, pop and compare it.
  task automatic monitor_step();
    wr_t w;
    if (rf_wen !== '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_wen", rf_wen, '0);
      end else begin
        w = exp_q.pop_front();
        check("wr_wsel", rf_wsel, w.wsel);
        check("wr_wen", rf_wen, w.wen);
        check("wr_wdata", rf_wdata, w.wdata);
        check("wr_cycle", cyc, w.due);
        for (int i = 0; i < THREADS; i++)
          if (rf_wen[i]) act_rf[rf_wsel][i*WORD_W +: WORD_W] = rf_wdata[i*WORD_W +: WORD_W];
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      check("missing_write_wen", rf_wen, exp_q[0].wen);
      void'(exp_q.pop_front());
    end
    check("idle", idle, (alu_q.size() == 0 && lsu_q.size() == 0 && exp_wen_now == '0));
  endtask

  initial forever begin
    @(negedge clk);
    if (nRST) monitor_step();
  end

  // Advance to the next falling edge, check readiness, then drive inputs.
  task automatic drive(input bit av, input req_t a, input bit lv, input req_t l);
    @(negedge clk);
    check("alu_ready", alu_ready, alu_q.size() < 2);
    check("lsu_ready", lsu_ready, lsu_q.size() < 2);
    alu_valid = av;
    alu_wsel  = a.wsel;
    alu_wen   = a.wen;
    alu_wdata = a.wdata;
    lsu_valid = lv;
    lsu_wsel  = l.wsel;
    lsu_wen   = l.wen;
    lsu_wdata = l.wdata;
  endtask

  task automatic drive_idle();
    drive(1'b0, mk(5'd0, '0, '0), 1'b0, mk(5'd0, '0, '0));
  endtask

  task automatic apply_reset();
    drive_idle();
    nRST = 1'b0;
    repeat (2) @(negedge clk);
    nRST = 1'b1;
  endtask

  task automatic random_phase(input int n);
    req_t a;
    req_t l;
    bit   av;
    bit   lv;
    for (int i = 0; i < n; i++) begin
      av = ($urandom_range(0, 99) < 60);
      lv = ($urandom_range(0, 99) < 60);
      a  = mk(($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), 4'($urandom), rand_data());
      l  = mk(($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), 4'($urandom), rand_data());
      drive(av, a, lv, l);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  alu_low_run;
    int  lsu_low_run;
    int  alu_low_max;
    int  lsu_low_max;
    bit  lsu_low_seen;
    int  exp_sel;
    bit  drained;

    // Reset state while nRST is held low.
    nRST = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rf_wsel", rf_wsel, 5'd0);
    check("rst_rf_wen", rf_wen, '0);
    check("rst_rf_wdata", rf_wdata, '0);
    check("rst_alu_ready", alu_ready, 1'b1);
    check("rst_lsu_ready", lsu_ready, 1'b1);
    check("rst_idle", idle, 1'b1);
    nRST = 1'b1;

    // Single ALU request to r5 with all lanes enabled.
    drive(1'b1, mk(5'd5, 4'b1111, {32'h44, 32'h33, 32'h22, 32'h11}), 1'b0, mk(5'd0, '0, '0));
    drive_idle();
    drive_idle();
    check("single_rf_wsel", rf_wsel, 5'd5);
    check("single_rf_wen", rf_wen, 4'b1111);
    check("single_rf_wdata", rf_wdata, {32'h44, 32'h33, 32'h22, 32'h11});
    drive_idle();
    check("single_rf_wen_after", rf_wen, '0);
    check("single_idle_after", idle, 1'b1);

    // Contention from reset: both saturate, grants must alternate 1,2,1,2.
    apply_reset();
    alu_low_run  = 0;
    lsu_low_run  = 0;
    alu_low_max  = 0;
    lsu_low_max  = 0;
    lsu_low_seen = 1'b0;
    exp_sel      = 1;
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, mk(5'd1, 4'b1111, rand_data()), 1'b1, mk(5'd2, 4'b1111, rand_data()));
      if (i >= 2) begin
        check("contention_order", rf_wsel, exp_sel);
        exp_sel = (exp_sel == 1) ? 2 : 1;
      end
      alu_low_run = alu_ready ? 0 : alu_low_run + 1;
      lsu_low_run = lsu_ready ? 0 : lsu_low_run + 1;
      if (alu_low_run > alu_low_max) alu_low_max = alu_low_run;
      if (lsu_low_run > lsu_low_max) lsu_low_max = lsu_low_run;
      if (!lsu_ready) lsu_low_seen = 1'b1;
    end
    check("alu_ready_low_run_le1", alu_low_max <= 1, 1'b1);
    check("lsu_ready_low_run_le1", lsu_low_max <= 1, 1'b1);
    check("lsu_backpressure_seen", lsu_low_seen, 1'b1);

    // r0 suppression: ALU r0 granted first with no write, then LSU r7.
    apply_reset();
    drive(1'b1, mk(5'd0, 4'b1111, rand_data()), 1'b1, mk(5'd7, 4'b1111, rand_data()));
    drive_idle();
    drive_idle();
    check("r0_rf_wen", rf_wen, '0);
    check("r0_idle", idle, 1'b0);
    drive_idle();
    check("r0_next_lsu_wsel", rf_wsel, 5'd7);
    check("r0_next_lsu_wen", rf_wen, 4'b1111);

    // Partial lane mask from the LSU.
    drive(1'b0, mk(5'd0, '0, '0), 1'b1, mk(5'd9, 4'b0101, rand_data()));
    drive_idle();
    drive_idle();
    check("partial_rf_wen", rf_wen, 4'b0101);
    check("partial_rf_wsel", rf_wsel, 5'd9);

    // Randomised traffic.
    random_phase(500);

    // Asynchronous reset mid-cycle with both buffers occupied.
    for (int i = 0; i < 6; i++)
      drive(1'b1, mk(5'($urandom_range(1, 31)), 4'b1111, rand_data()),
            1'b1, mk(5'($urandom_range(1, 31)), 4'b1111, rand_data()));
    drive_idle();
    check("prereset_busy", idle, 1'b0);
    #2;
    nRST = 1'b0;
    #1;
    check("async_rf_wsel", rf_wsel, 5'd0);
    check("async_rf_wen", rf_wen, '0);
    check("async_rf_wdata", rf_wdata, '0);
    check("async_alu_ready", alu_ready, 1'b1);
    check("async_lsu_ready", lsu_ready, 1'b1);
    check("async_idle", idle, 1'b1);
    repeat (2) @(negedge clk);
    nRST = 1'b1;
    repeat (4) drive_idle();
    check("postreset_idle", idle, 1'b1);

    random_phase(300);

    // Drain, bounded.
    drained = 1'b0;
    for (int i = 0; i < 20 && !drained; i++) begin
      drive_idle();
      drained = (alu_q.size() == 0 && lsu_q.size() == 0 && exp_q.size() == 0);
    end
    check("drain_complete", drained, 1'b1);
    repeat (2) drive_idle();
    for (int r = 0; r < 32; r++) check($sformatf("regfile_r%0d", r), act_rf[r], exp_rf[r]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_writeback_arbiter.md
VECTOR_WRITEBACK_ARBITER -- requirements
Module: vector_writeback_arbiter

Interface
REQ-001 SHALL have parameter THREADS, default 4, number of SIMT lanes per register.
REQ-002 SHALL have parameter WORD_W, default 32, bits per lane word.
REQ-003 SHALL have port clk input 1: single clock; all state on posedge clk.
REQ-004 SHALL have port nRST input 1: reset, asynchronous, active-low.
REQ-005 SHALL have port alu_valid input 1: ALU writeback request.
REQ-006 SHALL have port alu_ready output 1: ALU request accepted this edge when high with alu_valid.
REQ-007 SHALL have port alu_wsel input 5: ALU destination register.
REQ-008 SHALL have port alu_wen input THREADS: ALU per-lane write mask.
REQ-009 SHALL have port alu_wdata input THREADS*WORD_W: ALU lane data, lane i at bits [i*WORD_W +: WORD_W].
REQ-010 SHALL have ports lsu_valid, lsu_ready, lsu_wsel, lsu_wen, lsu_wdata, identical to REQ-005..009 for the load/store unit.
REQ-011 SHALL have port rf_wsel output 5: register-file write select.
REQ-012 SHALL have port rf_wen output THREADS: register-file per-lane write enable.
REQ-013 SHALL have port rf_wdata output THREADS*WORD_W: register-file write data.
REQ-014 SHALL have port idle output 1: both buffers empty and no write on rf outputs.

Function
REQ-015 SHALL hold per requester a 2-entry FIFO of {wsel, wen, wdata}, count 0..2.
REQ-016 SHALL drive x_ready = (count_x < 2), combinational from count only, independent of x_valid and of same-cycle pops.
REQ-017 SHALL push on edge where x_valid && x_ready; data is not visible to the arbiter until the following cycle, with no bypass.
REQ-018 SHALL keep a 1-bit priority pointer, where 0 means ALU-first and 1 means LSU-first.
REQ-019 SHALL arbitrate each cycle: if only one FIFO is non-empty, grant it; if both are non-empty, grant the pointer's requester.
REQ-020 SHALL, on a grant, pop that FIFO head at the edge and set the pointer to the non-granted requester; with no grant the pointer holds.
REQ-021 SHALL register outputs: the granted head loads rf_wsel/rf_wen/rf_wdata at the grant edge; with no grant, rf_wen is 0 and rf_wsel/rf_wdata hold.
REQ-022 SHALL force rf_wen to 0 when the granted entry has wsel==0 (r0 never written); the entry is still popped and the pointer still updates.
REQ-023 SHALL pass an entry with wen==0 as a normal grant with rf_wen=0.
REQ-024 SHALL have latency: accepted at edge k → earliest on rf outputs after edge k+1 → committed by the register file at edge k+2.
REQ-025 SHALL have throughput: one write per cycle total; with both requesters saturated, grants alternate strictly ALU/LSU.
REQ-026 SHALL preserve FIFO order per requester; same-wsel entries from different requesters reach rf in grant order (no merging).
REQ-027 SHALL, for simultaneous push and pop on one FIFO (count 1), leave count at 1 with the new entry becoming the head next cycle.
REQ-028 SHALL drive idle = (count_alu==0 && count_lsu==0 && rf_wen==0).

Reset
REQ-029 SHALL, while nRST is low: clear both counts to 0, set pointer to 0, and set rf_wsel, rf_wen and rf_wdata to 0; alu_ready=1, lsu_ready=1, idle=1.
REQ-030 SHALL, on reset mid-operation, discard all buffered entries with no partial write; the first post-reset grant follows REQ-019 from pointer 0.

Verification
REQ-031 SHALL cover single ALU request: alu_wsel=5, alu_wen=4'b1111, lanes 0x11..0x44 at edge k → rf_wsel=5, rf_wen=4'b1111, data matching after edge k+1; rf_wen=0 after edge k+2; idle=1.
REQ-032 SHALL cover contention: both valid every cycle from reset (wsel 1 ALU, 2 LSU) → rf_wsel sequence 1,2,1,2,…; neither ready drops below 1 for more than one cycle; no entry is lost.
REQ-033 SHALL cover backpressure: lsu_valid held high with ALU saturating and pointer favouring ALU → lsu_ready low once lsu count is 2; no push occurs while low.
REQ-034 SHALL cover r0 suppression: alu_wsel=0, alu_wen=4'b1111 → rf_wen=0 at the grant cycle, pointer flips, next LSU entry is granted.
REQ-035 SHALL cover partial mask: lsu_wen=4'b0101 → rf_wen=4'b0101 and only lanes 0 and 2 are changed in the register file model.
REQ-036 SHALL cover async reset: nRST asserted mid-cycle with both FIFOs full → outputs zero immediately without waiting for clk; after release, counts are 0, no stale writes appear, alu_ready=lsu_ready=1.
